fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter DATA_W, default 16, signed width of each real/imaginary sample.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port valid_i  input  1  sample strobe; one sample accepted per rising edge where high.
REQ-005 Port data_in_r / data_in_i  input  DATA_W each  FFT pipeline output, arriving in bit-reversed order.
REQ-006 Port valid_o  output  1  output sample valid.
REQ-007 Port data_out_r / data_out_i  output  DATA_W each  sample in natural frequency order.
REQ-008 Port index_o  output  5  natural bin index (0..31) of current output sample.

Function
REQ-009 Two 32-entry complex banks (ping-pong); write bank and read bank always distinct.
REQ-010 5-bit write counter wr_cnt; on accepted sample, store at address bitrev(wr_cnt) of write bank, then wr_cnt+1.
REQ-011 Sample accepted with wr_cnt=31: wr_cnt wraps to 0, full flag of that bank set, write bank toggles, all on the same edge.
REQ-012 Read FSM: IDLE / READ; IDLE->READ on the edge where read bank's full flag is set (or is being set).
REQ-013 In READ, each edge: valid_o<=1, data_out<=mem[rd_bank][rd_cnt], index_o<=rd_cnt, rd_cnt+1; one sample per cycle, no stalls.
REQ-014 On READ edge with rd_cnt=31: clear rd_bank full flag, toggle rd_bank, rd_cnt<=0; stay READ if new rd_bank full or set on this edge, else IDLE.
REQ-015 Latency: 32nd sample of a frame accepted at edge T -> index 0 valid after edge T+1; index n after edge T+1+n.
REQ-016 Back-to-back frames (valid_i continuously high) produce continuous valid_o with no bubble; index_o wraps 31->0.
REQ-017 In IDLE, valid_o=0; data_out_r/i and index_o hold last value.
REQ-018 Gaps in valid_i only delay frame completion; output burst per frame is always 32 contiguous cycles.
REQ-019 Data passed bit-exact; no scaling, rounding or saturation.
REQ-020 Overflow impossible by construction (write rate <= 1/cycle, read = 32 cycles); no error output.

Reset
REQ-021 rst high asynchronously clears: valid_o, data_out_r, data_out_i, index_o to 0; wr_cnt, rd_cnt, both full flags to 0; write bank=0, read bank=0; FSM=IDLE.
REQ-022 Bank memories not reset; partial or unread frames are discarded by reset.
REQ-023 First sample accepted on the first edge after rst deasserts with valid_i high.

Configuration
REQ-024 Macro FFT_REORDER_SOF_EN defined: adds input port sof_i (1 bit); valid_i & sof_i forces the sample to wr_cnt=0 (address 0), discarding any partial frame in the write bank; bank full flags unaffected.
REQ-025 FFT_REORDER_SOF_EN undefined: sof_i port absent; wr_cnt free-running from reset.

Verification
REQ-026 Reset, one frame: k-th input data_in_r=bitrev(k), data_in_i=-bitrev(k) -> 32 consecutive valid_o starting edge after 32nd input, output n has data_out_r=n, data_out_i=-n, index_o=n.
REQ-027 Three frames, valid_i held high 96 cycles, frame f values 100*f+bin -> valid_o high 96 consecutive cycles, values 0..31,100..131,200..231 in order.
REQ-028 Valid_i toggling 1,0,1,0 for one frame -> identical values to REQ-026, output burst contiguous 32 cycles.
REQ-029 20 samples, rst pulse, then full frame of 500+bin -> exactly 32 outputs, all 500..531; no output from partial frame.
REQ-030 Rst asserted mid-read at index_o=12 -> valid_o, data_out, index_o 0 immediately (before next edge); no further output.
REQ-031 With FFT_REORDER_SOF_EN: 10 samples, then sof_i on first of a 32-sample frame 700+bin -> only 700..731 output; without macro, design elaborates with no sof_i port.

Source files
------------

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for a 32-point FFT (ping-pong banks).
// Define FFT_REORDER_SOF_EN to add sof_i, which realigns the write counter to a frame start.
module fft_reorder #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
`ifdef FFT_REORDER_SOF_EN
  input  logic              sof_i,
`endif
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i,
  output logic [4:0]        index_o
);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRead = 1'b1;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    return {v[0], v[1], v[2], v[3], v[4]};
  endfunction

  // Both banks share one array; the bank select is the address MSB.
  logic [DATA_W-1:0] mem_r [64];
  logic [DATA_W-1:0] mem_i [64];

  logic [4:0]        wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic [1:0]        full_q, full_d;
  logic              rd_bank_q, rd_bank_d;
  logic [4:0]        rd_cnt_q, rd_cnt_d;
  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dout_r_q, dout_r_d;
  logic [DATA_W-1:0] dout_i_q, dout_i_d;
  logic [4:0]        index_q, index_d;

  logic       sof;
  logic [4:0] wr_addr;
  logic [1:0] set_mask, clr_mask, full_now;

`ifdef FFT_REORDER_SOF_EN
  assign sof = valid_i & sof_i;
`else
  assign sof = 1'b0;
`endif

  assign wr_addr = sof ? 5'd0 : bitrev5(wr_cnt_q);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    set_mask  = 2'b00;
    if (sof) begin
      wr_cnt_d = 5'd1;
    end else if (valid_i) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
      if (wr_cnt_q == 5'd31) begin
        wr_bank_d           = ~wr_bank_q;
        set_mask[wr_bank_q] = 1'b1;
      end
    end
  end

  // Flags being set this edge count as full so a completed frame starts reading at once.
  assign full_now = full_q | set_mask;

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    clr_mask  = 2'b00;
    valid_d   = 1'b0;
    dout_r_d  = dout_r_q;
    dout_i_d  = dout_i_q;
    index_d   = index_q;
    case (state_q)
      StIdle: begin
        if (full_now[rd_bank_q]) state_d = StRead;
      end
      StRead: begin
        valid_d  = 1'b1;
        dout_r_d = mem_r[{rd_bank_q, rd_cnt_q}];
        dout_i_d = mem_i[{rd_bank_q, rd_cnt_q}];
        index_d  = rd_cnt_q;
        rd_cnt_d = rd_cnt_q + 5'd1;
        if (rd_cnt_q == 5'd31) begin
          clr_mask[rd_bank_q] = 1'b1;
          rd_bank_d           = ~rd_bank_q;
          if (!full_now[rd_bank_d]) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign full_d = full_now & ~clr_mask;

  always_ff @(posedge clk) begin
    if (valid_i) begin
      mem_r[{wr_bank_q, wr_addr}] <= data_in_r;
      mem_i[{wr_bank_q, wr_addr}] <= data_in_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q  <= 5'd0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      rd_bank_q <= 1'b0;
      rd_cnt_q  <= 5'd0;
      state_q   <= StIdle;
      valid_q   <= 1'b0;
      dout_r_q  <= '0;
      dout_i_q  <= '0;
      index_q   <= 5'd0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      rd_bank_q <= rd_bank_d;
      rd_cnt_q  <= rd_cnt_d;
      state_q   <= state_d;
      valid_q   <= valid_d;
      dout_r_q  <= dout_r_d;
      dout_i_q  <= dout_i_d;
      index_q   <= index_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_out_r = dout_r_q;
  assign data_out_i = dout_i_q;
  assign index_o    = index_q;

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: frame tables plus reset, latency and SOF corner sequences.
module tb_fft_reorder;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i;
  logic [DW-1:0] data_in_r, data_in_i;
  logic          valid_o;
  logic [DW-1:0] data_out_r, data_out_i;
  logic [4:0]    index_o;
`ifdef FFT_REORDER_SOF_EN
  logic          sof_i;
`endif

  always #5 clk = ~clk;

  fft_reorder #(.DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
`ifdef FFT_REORDER_SOF_EN
    .sof_i      (sof_i),
`endif
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .valid_o    (valid_o),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .index_o    (index_o)
  );

  int checks = 0;
  int errors = 0;

  logic signed [31:0] q_r[$], q_i[$], q_idx[$];
  int q_t[$];
  int tick = 0;

  always @(negedge clk) begin
    tick <= tick + 1;
    if (valid_o === 1'b1) begin
      q_r.push_back(32'($signed(data_out_r)));
      q_i.push_back(32'($signed(data_out_i)));
      q_idx.push_back(32'(index_o));
      q_t.push_back(tick);
    end
  end

  typedef struct {
    string name;
    int    nframes;
    bit    gaps;
    int    step;
    int    exp_count;
    int    exp_last_r;
  } scen_t;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if (k[b]) r |= (1 << (4 - b));
    return r;
  endfunction

  task automatic clear_q();
    q_r.delete(); q_i.delete(); q_idx.delete(); q_t.delete();
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input int r, input int i, input bit sof);
    valid_i   = 1'b1;
    data_in_r = r[DW-1:0];
    data_in_i = i[DW-1:0];
`ifdef FFT_REORDER_SOF_EN
    sof_i = sof;
`else
    if (sof) valid_i = 1'b1;
`endif
    @(posedge clk); #1;
    valid_i = 1'b0;
`ifdef FFT_REORDER_SOF_EN
    sof_i = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input bit gaps, input bit sof_first);
    for (int k = 0; k < 32; k++) begin
      send(base + brev(k), -(base + brev(k)), sof_first && (k == 0));
      if (gaps && k < 31) idle(1);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_outputs(input int n, input string name);
    int t = 0;
    while (q_r.size() < n && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    check({name, "_timeout"}, 32'(q_r.size() >= n), 32'd1);
  endtask

  task automatic check_stream(input string name, input int exp_count, input int step,
                              input int base);
    int n, bad;
    logic signed [31:0] v;
    check({name, "_count"}, q_r.size(), exp_count);
    n = (q_r.size() < exp_count) ? q_r.size() : exp_count;
    for (int j = 0; j < n; j++) begin
      v = base + (j / 32) * step + (j % 32);
      check({name, "_r"}, q_r[j], v);
      check({name, "_i"}, q_i[j], -v);
      check({name, "_idx"}, q_idx[j], j % 32);
    end
    bad = 0;
    for (int j = 1; j < q_t.size(); j++) if (q_t[j] != q_t[j-1] + 1) bad++;
    check({name, "_contig"}, bad, 0);
  endtask

  scen_t tbl[3];

  initial begin
    int t;
    tbl[0] = '{name: "one_frame",    nframes: 1, gaps: 1'b0, step: 0,   exp_count: 32,
               exp_last_r: 31};
    tbl[1] = '{name: "three_frames", nframes: 3, gaps: 1'b0, step: 100, exp_count: 96,
               exp_last_r: 231};
    tbl[2] = '{name: "gapped",       nframes: 1, gaps: 1'b1, step: 0,   exp_count: 32,
               exp_last_r: 31};

    rst = 1'b0; valid_i = 1'b0; data_in_r = '0; data_in_i = '0;
`ifdef FFT_REORDER_SOF_EN
    sof_i = 1'b0;
`endif
    #1 rst = 1'b1;
    #1;
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data_r", 32'(data_out_r), 0);
    check("rst_data_i", 32'(data_out_i), 0);
    check("rst_index", 32'(index_o), 0);
    @(posedge clk); #1 rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      do_reset();
      clear_q();
      for (int f = 0; f < tbl[s].nframes; f++) send_frame(f * tbl[s].step, tbl[s].gaps, 1'b0);
      wait_outputs(tbl[s].exp_count, tbl[s].name);
      idle(5);
      check_stream(tbl[s].name, tbl[s].exp_count, tbl[s].step, 0);
      if (q_r.size() > 0) check({tbl[s].name, "_last"}, q_r[$], tbl[s].exp_last_r);
    end

    // Partial frame discarded by reset, then full frame with latency check.
    do_reset();
    clear_q();
    for (int k = 0; k < 20; k++) send(900 + brev(k), -(900 + brev(k)), 1'b0);
    do_reset();
    send_frame(500, 1'b0, 1'b0);
    @(negedge clk);
    check("lat_pre_valid", 32'(valid_o), 0);
    @(negedge clk);
    check("lat_first_valid", 32'(valid_o), 1);
    check("lat_first_index", 32'(index_o), 0);
    @(posedge clk); #1;
    wait_outputs(32, "partial");
    idle(40);
    check_stream("partial", 32, 0, 500);

    // Asynchronous reset in the middle of a read burst.
    do_reset();
    clear_q();
    send_frame(0, 1'b0, 1'b0);
    t = 0;
    while (!(valid_o === 1'b1 && index_o == 5'd12) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("midrd_found", 32'(t < 100), 1);
    #2 rst = 1'b1;
    #1;
    check("midrd_valid", 32'(valid_o), 0);
    check("midrd_data_r", 32'(data_out_r), 0);
    check("midrd_data_i", 32'(data_out_i), 0);
    check("midrd_index", 32'(index_o), 0);
    check("midrd_seen", q_r.size(), 13);
    @(posedge clk); #1 rst = 1'b0;
    idle(40);
    check("midrd_after", q_r.size(), 13);

`ifdef FFT_REORDER_SOF_EN
    do_reset();
    clear_q();
    for (int k = 0; k < 10; k++) send(900 + brev(k), -(900 + brev(k)), 1'b0);
    send_frame(700, 1'b0, 1'b1);
    wait_outputs(32, "sof");
    idle(40);
    check_stream("sof", 32, 0, 700);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
